// File: rtl/vec_pkg.sv
// Shared constants and encodings for the dot-product sequencer.
// Memory map, state codes and memory opcodes live here.
package vec_pkg;

  localparam int WORD_BITS  = 4;
  localparam int MAX_LEN    = 16;
  localparam int VEC_A_BASE = 1;
  localparam int VEC_B_BASE = 17;
  localparam int OUT_BASE   = 33;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RUN   = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_MAC,
    S_WRITE_LO,
    S_WRITE_HI,
    S_DONE
  } fsm_e;

  function automatic logic [1:0] state_code(input fsm_e s);
    logic [1:0] c;
    c = ST_RUNNING;
    if (s == S_IDLE) c = ST_IDLE;
    if (s == S_DONE) c = ST_DONE;
    return c;
  endfunction

endpackage

// File: rtl/nibble_mac.sv
// 4x4 unsigned multiply feeding a 12-bit accumulator.
// clr wins over en so a new run always starts from zero.
module nibble_mac (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  output logic [11:0] acc
);

  logic [11:0] acc_q, acc_d;
  logic [7:0]  prod;

  always_comb begin
    prod  = {4'b0, a} * {4'b0, b};
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + {4'b0, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_sequencer.sv
// Reads vectors A and B from shared memory, accumulates their
// dot product and writes the low byte back as two nibbles.
module dot_product_sequencer #(
  parameter int WORD_BITS  = vec_pkg::WORD_BITS,
  parameter int MAX_LEN    = vec_pkg::MAX_LEN,
  parameter int VEC_A_BASE = vec_pkg::VEC_A_BASE,
  parameter int VEC_B_BASE = vec_pkg::VEC_B_BASE,
  parameter int OUT_BASE   = vec_pkg::OUT_BASE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clear,
  input  logic [4:0]           len,
  output logic [5:0]           mem_addr,
  output logic                 mem_rd_en,
  input  logic [WORD_BITS-1:0] mem_rd_data,
  output logic                 mem_wr_en,
  output logic [WORD_BITS-1:0] mem_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state,
  output logic [7:0]           result,
  output logic                 overflow
);

  import vec_pkg::*;

  localparam logic [5:0] A_BASE = 6'(VEC_A_BASE);
  localparam logic [5:0] B_BASE = 6'(VEC_B_BASE);
  localparam logic [5:0] O_BASE = 6'(OUT_BASE);
  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

  fsm_e        state_q, state_d;
  logic [4:0]  n_q, i_q;
  logic [3:0]  a_q;
  logic [7:0]  result_q;
  logic        ovf_q;
  logic [11:0] acc;
  logic [4:0]  len_c;
  logic        idle_or_done;
  logic        go;
  op_e         op;
  logic [5:0]  addr;
  logic [3:0]  wdata;

  assign len_c = (len > LEN_MAX) ? LEN_MAX : len;
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign go = idle_or_done && start && !abort;

  nibble_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (state_q == S_MAC),
    .a     (a_q),
    .b     (mem_rd_data[3:0]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go)
          state_d = (len_c == 5'd0) ? S_WRITE_LO : S_FETCH_A;
        else if (state_q == S_DONE && (abort || clear))
          state_d = S_IDLE;
      end
      S_FETCH_A:  state_d = abort ? S_IDLE : S_FETCH_B;
      S_FETCH_B:  state_d = abort ? S_IDLE : S_MAC;
      S_MAC: begin
        if (abort)
          state_d = S_IDLE;
        else if (i_q + 5'd1 < n_q)
          state_d = S_FETCH_A;
        else
          state_d = S_WRITE_LO;
      end
      S_WRITE_LO: state_d = abort ? S_IDLE : S_WRITE_HI;
      S_WRITE_HI: state_d = abort ? S_IDLE : S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      i_q      <= '0;
      a_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (go) begin
        n_q <= len_c;
        i_q <= '0;
      end else if (state_q == S_MAC) begin
        i_q <= i_q + 5'd1;
      end
      if (state_q == S_FETCH_B)
        a_q <= mem_rd_data[3:0];
      // Only a completed write-back publishes a new result.
      if (state_q == S_WRITE_HI && state_d == S_DONE) begin
        result_q <= acc[7:0];
        ovf_q    <= |acc[11:8];
      end
    end
  end

  always_comb begin
    op    = OP_RUN;
    addr  = '0;
    wdata = '0;
    unique case (state_q)
      S_FETCH_A: begin
        op   = OP_READ;
        addr = A_BASE + {1'b0, i_q};
      end
      S_FETCH_B: begin
        op   = OP_READ;
        addr = B_BASE + {1'b0, i_q};
      end
      S_WRITE_LO: begin
        op    = OP_WRITE;
        addr  = O_BASE;
        wdata = acc[3:0];
      end
      S_WRITE_HI: begin
        op    = OP_WRITE;
        addr  = O_BASE + 6'd1;
        wdata = acc[7:4];
      end
      default: op = OP_RUN;
    endcase
  end

  assign mem_addr    = addr;
  assign mem_rd_en   = (op == OP_READ);
  assign mem_wr_en   = (op == OP_WRITE);
  assign mem_wr_data = wdata;
  assign state       = state_code(state_q);
  assign busy        = (state == ST_RUNNING);
  assign done        = (state == ST_DONE);
  assign result      = result_q;
  assign overflow    = ovf_q;

endmodule
